// File: rtl/ha_config_sequencer.sv
// Replays a host-written context table into an overlay: per context, strobes the config register, then switches GlobalSel and dwells.
// Latency: first EN one cycle after the start edge; GlobalSel follows EN by one cycle; each context takes 1 + max(dwell,1) cycles.
// Backpressure: table writes are accepted only in IDLE (wr_ready); writes and starts outside IDLE are dropped.
module ha_config_sequencer #(
    parameter int INST_BW = 3,
    parameter int GSEL_BW = 3,
    parameter int DEPTH   = 4,
    parameter int CNT_BW  = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INST_BW-1:0] wr_inst,
    input  logic [GSEL_BW-1:0] wr_gsel,
    input  logic [CNT_BW-1:0]  wr_dwell,
    input  logic               start,
    input  logic [AW:0]        num_ctx,
    input  logic               loop_en,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      ctx_idx,
    output logic               Config_Reg_EN,
    output logic [INST_BW-1:0] Config_Reg_InstIn,
    output logic [GSEL_BW-1:0] GlobalSel
);

    typedef struct packed {
        logic [INST_BW-1:0] inst;
        logic [GSEL_BW-1:0] gsel;
        logic [CNT_BW-1:0]  dwell;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DWELL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

    entry_t             tbl_q [DEPTH];
    state_t             state_q;
    logic [AW-1:0]      idx_q;
    logic [AW-1:0]      last_q;
    logic [CNT_BW-1:0]  cnt_q;
    logic               wr_ready_q;
    logic               busy_q;
    logic               done_q;
    logic               en_q;
    logic [INST_BW-1:0] inst_q;
    logic [GSEL_BW-1:0] gsel_q;

    logic               wr_fire;
    entry_t             wr_entry;
    entry_t             first_entry_d;
    logic [AW-1:0]      next_idx_d;
    entry_t             next_entry_d;

    // A zero dwell still holds the context for one cycle.
    function automatic logic [CNT_BW-1:0] dwell_cycles(input logic [CNT_BW-1:0] d);
        return (d == '0) ? CNT_BW'(1) : d;
    endfunction

    assign wr_fire  = wr_valid && wr_ready_q;
    assign wr_entry = '{inst: wr_inst, gsel: wr_gsel, dwell: wr_dwell};

    // Entry 0 as seen by a start on the same edge as a write: the write wins.
    always_comb begin
        first_entry_d = tbl_q[0];
        if (wr_fire && (wr_addr == '0)) begin
            first_entry_d = wr_entry;
        end
        next_idx_d   = (idx_q < last_q) ? idx_q + AW'(1) : '0;
        next_entry_d = tbl_q[next_idx_d];
    end

    // Context table: cleared on reset, written only while IDLE advertises ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (wr_fire) begin
            tbl_q[wr_addr] <= wr_entry;
        end
    end

    // Sequencer FSM with every output registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            cnt_q      <= '0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            en_q       <= 1'b0;
            inst_q     <= '0;
            gsel_q     <= '0;
        end else begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    wr_ready_q <= 1'b1;
                    if (start && (num_ctx != '0)) begin
                        last_q     <= (num_ctx > DEPTH_W) ? LAST_MAX : AW'(num_ctx - 1'b1);
                        idx_q      <= '0;
                        inst_q     <= first_entry_d.inst;
                        cnt_q      <= dwell_cycles(first_entry_d.dwell);
                        en_q       <= 1'b1;
                        busy_q     <= 1'b1;
                        wr_ready_q <= 1'b0;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    gsel_q  <= tbl_q[idx_q].gsel;
                    state_q <= S_DWELL;
                end
                S_DWELL: begin
                    if (cnt_q == CNT_BW'(1)) begin
                        if ((idx_q != last_q) || loop_en) begin
                            idx_q   <= next_idx_d;
                            inst_q  <= next_entry_d.inst;
                            cnt_q   <= dwell_cycles(next_entry_d.dwell);
                            en_q    <= 1'b1;
                            state_q <= S_LOAD;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_BW'(1);
                    end
                end
                default: begin
                    wr_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_ready          = wr_ready_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign ctx_idx           = idx_q;
    assign Config_Reg_EN     = en_q;
    assign Config_Reg_InstIn = inst_q;
    assign GlobalSel         = gsel_q;

endmodule

// File: tb/tb_ha_config_sequencer.sv
// Self-checking bench for ha_config_sequencer: directed vectors, a timeline reference model, and randomized runs.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
// All waits are fixed-length loops, so the bench always terminates.
module tb_ha_config_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [1:0] wr_addr = '0;
    logic [2:0] wr_inst = '0;
    logic [2:0] wr_gsel = '0;
    logic [7:0] wr_dwell = '0;
    logic       start = 1'b0;
    logic [2:0] num_ctx = '0;
    logic       loop_en = 1'b0;
    logic       busy;
    logic       done;
    logic [1:0] ctx_idx;
    logic       Config_Reg_EN;
    logic [2:0] Config_Reg_InstIn;
    logic [2:0] GlobalSel;

    ha_config_sequencer #(.INST_BW(3), .GSEL_BW(3), .DEPTH(4), .CNT_BW(8)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_inst(wr_inst), .wr_gsel(wr_gsel), .wr_dwell(wr_dwell),
        .start(start), .num_ctx(num_ctx), .loop_en(loop_en),
        .busy(busy), .done(done), .ctx_idx(ctx_idx),
        .Config_Reg_EN(Config_Reg_EN), .Config_Reg_InstIn(Config_Reg_InstIn),
        .GlobalSel(GlobalSel)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: table contents and the last-held output values.
    int m_inst [4];
    int m_gsel [4];
    int m_dw   [4];
    int m_cur_inst = 0;
    int m_cur_gsel = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Host write issued while the DUT is idle; the model table follows it.
    task automatic wr(input int a, input int inst, input int gsel, input int dw);
        wr_valid = 1'b1;
        wr_addr  = 2'(a);
        wr_inst  = 3'(inst);
        wr_gsel  = 3'(gsel);
        wr_dwell = 8'(dw);
        step();
        wr_valid = 1'b0;
        m_inst[a] = inst;
        m_gsel[a] = gsel;
        m_dw[a]   = dw;
    endtask

    // Builds the expected cycle timeline from the table, then checks it cycle by cycle.
    task automatic run_and_check(input int nc);
        int n, len, d;
        int e_en[64], e_inst[64], e_gsel[64], e_busy[64], e_done[64], e_ctx[64];
        int cur_gsel;
        n = (nc > 4) ? 4 : nc;
        len = 0;
        cur_gsel = m_cur_gsel;
        for (int i = 0; i < n; i++) begin
            d = (m_dw[i] == 0) ? 1 : m_dw[i];
            for (int j = 0; j <= d; j++) begin
                e_en[len]   = (j == 0) ? 1 : 0;
                e_inst[len] = m_inst[i];
                e_gsel[len] = (j == 0) ? cur_gsel : m_gsel[i];
                e_busy[len] = 1;
                e_done[len] = 0;
                e_ctx[len]  = i;
                len++;
            end
            cur_gsel = m_gsel[i];
        end
        if (n > 0) begin
            e_en[len]   = 0;
            e_inst[len] = m_inst[n-1];
            e_gsel[len] = cur_gsel;
            e_busy[len] = 0;
            e_done[len] = 1;
            e_ctx[len]  = n - 1;
            len++;
        end
        start   = 1'b1;
        num_ctx = 3'(nc);
        step();
        start = 1'b0;
        if (n == 0) begin
            for (int k = 0; k < 3; k++) begin
                chk("zero_ctx_en", int'(Config_Reg_EN), 0);
                chk("zero_ctx_done", int'(done), 0);
                chk("zero_ctx_busy", int'(busy), 0);
                step();
            end
            return;
        end
        for (int k = 0; k < len; k++) begin
            chk("seq_en", int'(Config_Reg_EN), e_en[k]);
            chk("seq_inst", int'(Config_Reg_InstIn), e_inst[k]);
            chk("seq_gsel", int'(GlobalSel), e_gsel[k]);
            chk("seq_busy", int'(busy), e_busy[k]);
            chk("seq_done", int'(done), e_done[k]);
            chk("seq_ctx", int'(ctx_idx), e_ctx[k]);
            chk("seq_wr_ready", int'(wr_ready), 0);
            if (k == 1) begin
                start   = 1'b1;
                num_ctx = 3'($urandom_range(1, 7));
            end
            step();
            start = 1'b0;
        end
        chk("after_done", int'(done), 0);
        chk("after_wr_ready", int'(wr_ready), 1);
        chk("after_en", int'(Config_Reg_EN), 0);
        m_cur_inst = m_inst[n-1];
        m_cur_gsel = cur_gsel;
    endtask

    typedef struct {
        int nc;
        int exp_done_cyc;
        int exp_en_cnt;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int en_cnt, done_cyc, first_inst;
        int en_at [8];

        vecs[0] = '{1, 4, 1};
        vecs[1] = '{2, 6, 2};
        vecs[2] = '{3, 10, 3};
        vecs[3] = '{4, 12, 4};
        vecs[4] = '{7, 12, 4};
        vecs[5] = '{0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            m_inst[i] = 0; m_gsel[i] = 0; m_dw[i] = 0;
        end

        // Reset held for three cycles.
        rst = 1'b0;
        step(); step(); step();
        chk("rst_wr_ready", int'(wr_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_en", int'(Config_Reg_EN), 0);
        chk("rst_inst", int'(Config_Reg_InstIn), 0);
        chk("rst_gsel", int'(GlobalSel), 0);
        chk("rst_ctx", int'(ctx_idx), 0);
        rst = 1'b1;
        step();
        chk("idle_wr_ready", int'(wr_ready), 1);
        chk("idle_busy", int'(busy), 0);

        wr(0, 3'b101, 3'b010, 2);
        wr(1, 3'b011, 3'b111, 0);
        wr(2, 3'b001, 3'b100, 3);
        wr(3, 3'b111, 3'b001, 1);

        // Two-context run from the worked example, via the timeline model.
        run_and_check(2);

        // Table-driven: done cycle and EN count for several context counts.
        for (int v = 0; v < 6; v++) begin
            en_cnt = 0; done_cyc = 0; first_inst = -1;
            start   = 1'b1;
            num_ctx = 3'(vecs[v].nc);
            step();
            start = 1'b0;
            for (int c = 1; c <= 16; c++) begin
                if (Config_Reg_EN) begin
                    en_cnt++;
                    if (first_inst < 0) first_inst = int'(Config_Reg_InstIn);
                end
                if (done && done_cyc == 0) done_cyc = c;
                step();
            end
            chk("vec_done_cycle", done_cyc, vecs[v].exp_done_cyc);
            chk("vec_en_count", en_cnt, vecs[v].exp_en_cnt);
            if (vecs[v].nc != 0) chk("vec_first_inst", first_inst, 3'b101);
        end
        m_cur_inst = 3'b111;
        m_cur_gsel = 3'b001;

        // Looping: EN period 5 over two contexts; dropping loop_en finishes the current pass.
        en_cnt = 0; done_cyc = 0;
        loop_en = 1'b1;
        start   = 1'b1;
        num_ctx = 3'd2;
        step();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (Config_Reg_EN) begin
                if (en_cnt < 8) en_at[en_cnt] = c;
                en_cnt++;
            end
            if (done && done_cyc == 0) done_cyc = c;
            if (c == 7) loop_en = 1'b0;
            step();
        end
        chk("loop_en_count", en_cnt, 4);
        chk("loop_en0", en_at[0], 1);
        chk("loop_en1", en_at[1], 4);
        chk("loop_period", en_at[2] - en_at[0], 5);
        chk("loop_en3", en_at[3], 9);
        chk("loop_done_cycle", done_cyc, 11);
        m_cur_inst = 3'b011;
        m_cur_gsel = 3'b111;

        // Write and start on the same edge: the new entry 0 is used.
        wr_valid = 1'b1; wr_addr = 2'd0; wr_inst = 3'b110; wr_gsel = 3'b010; wr_dwell = 8'd2;
        start = 1'b1; num_ctx = 3'd1;
        step();
        wr_valid = 1'b0; start = 1'b0;
        m_inst[0] = 3'b110;
        chk("wrstart_en", int'(Config_Reg_EN), 1);
        chk("wrstart_inst", int'(Config_Reg_InstIn), 3'b110);
        // A write while busy is dropped.
        wr_valid = 1'b1; wr_addr = 2'd1; wr_inst = 3'b000; wr_gsel = 3'b000; wr_dwell = 8'd5;
        chk("busy_wr_ready", int'(wr_ready), 0);
        step();
        wr_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        m_cur_inst = 3'b110;
        m_cur_gsel = 3'b010;
        run_and_check(2);

        // Randomized runs against the timeline model.
        for (int it = 0; it < 20; it++) begin
            for (int w = 0; w < 4; w++) begin
                if ($urandom_range(0, 1) == 1)
                    wr(w, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 4));
            end
            run_and_check($urandom_range(0, 7));
        end

        // Reset during the dwell of context 1.
        wr(0, 3'b101, 3'b010, 2);
        wr(1, 3'b011, 3'b111, 3);
        start = 1'b1; num_ctx = 3'd2;
        step();
        start = 1'b0;
        for (int c = 0; c < 4; c++) step();
        chk("pre_rst_ctx", int'(ctx_idx), 1);
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_en", int'(Config_Reg_EN), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_gsel", int'(GlobalSel), 0);
        chk("midrst_inst", int'(Config_Reg_InstIn), 0);
        chk("midrst_ctx", int'(ctx_idx), 0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("postrst_no_en", int'(Config_Reg_EN), 0);
            chk("postrst_no_done", int'(done), 0);
        end
        chk("postrst_wr_ready", int'(wr_ready), 1);
        for (int i = 0; i < 4; i++) begin
            m_inst[i] = 0; m_gsel[i] = 0; m_dw[i] = 0;
        end
        m_cur_inst = 0;
        m_cur_gsel = 0;
        run_and_check(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
